// File: rtl/acq_sequencer.sv
// Periodic ADC acquisition scheduler: scans masked channels through convert, filter and compare.
// Latency: scan starts 1 cycle after tick/single_shot; at least 5 cycles per channel; scan_done 1 cycle after last NEXT.
// Backpressure: each stage waits on its done input (watchdog-bounded); a tick that arrives while busy is dropped and flagged.
module acq_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT       = 256,
    parameter int NCH           = 4,
    parameter int CHW           = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           single_shot,
    input  logic [NCH-1:0] ch_mask,
    input  logic           err_clr,
    input  logic           data_ready,
    input  logic           filter_done,
    input  logic           compare_done,
    output logic           start_conversion,
    output logic [CHW-1:0] adc_channel,
    output logic           filter_enable,
    output logic           compare_enable,
    output logic           busy,
    output logic           scan_done,
    output logic           timeout_err,
    output logic           overrun
);

    localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PERIOD_RELOAD = PW'(SAMPLE_PERIOD - 1);
    localparam logic [WW-1:0] WD_LAST       = WW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_WAIT_ADC = 3'd2;
    localparam logic [2:0] S_FILTER   = 3'd3;
    localparam logic [2:0] S_COMPARE  = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [PW-1:0]  period_q, period_d;
    logic [WW-1:0]  wd_q, wd_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic           start_q, start_d;
    logic           filt_q, filt_d;
    logic           cmp_q, cmp_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           tmo_q, tmo_d;
    logic           ovr_q, ovr_d;

    logic           tick;
    logic           wd_expire;
    logic           set_tmo;
    logic [CHW-1:0] low_idx;
    logic [CHW-1:0] nxt_idx;
    logic           nxt_found;

    // Sample-rate divider: counts down while enabled, held at reload otherwise.
    always_comb begin
        tick     = 1'b0;
        period_d = period_q;
        if (!enable) begin
            period_d = PERIOD_RELOAD;
        end else if (period_q == '0) begin
            tick     = 1'b1;
            period_d = PERIOD_RELOAD;
        end else begin
            period_d = period_q - PW'(1);
        end
    end

    // Channel pickers: lowest set bit of the live mask, next set bit above the current channel in the snapshot.
    always_comb begin
        low_idx   = '0;
        nxt_idx   = ch_q;
        nxt_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                low_idx = CHW'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = CHW'(i);
            end
        end
    end

    // Scan FSM: next state, snapshot/channel updates and watchdog abort.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ch_d      = ch_q;
        set_tmo   = 1'b0;
        wd_expire = (wd_q == WD_LAST);
        case (state_q)
            S_IDLE: begin
                if ((tick || single_shot) && (ch_mask != '0)) begin
                    mask_d  = ch_mask;
                    ch_d    = low_idx;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT_ADC;
            S_WAIT_ADC: begin
                if (data_ready) begin
                    state_d = S_FILTER;
                end else if (wd_expire) begin
                    set_tmo = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FILTER: begin
                if (filter_done) begin
                    state_d = S_COMPARE;
                end else if (wd_expire) begin
                    set_tmo = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (compare_done) begin
                    state_d = S_NEXT;
                end else if (wd_expire) begin
                    set_tmo = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_NEXT: begin
                if (nxt_found) begin
                    ch_d    = nxt_idx;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Watchdog: restarts on entry to a wait state, counts while staying there.
    always_comb begin
        wd_d = '0;
        if ((state_d == S_WAIT_ADC) || (state_d == S_FILTER) || (state_d == S_COMPARE)) begin
            if (state_d == state_q) begin
                wd_d = wd_q + WW'(1);
            end
        end
    end

    // Registered Moore outputs decoded from the next state; sticky flags where set beats clear.
    always_comb begin
        start_d = (state_d == S_START);
        filt_d  = (state_d == S_FILTER);
        cmp_d   = (state_d == S_COMPARE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_NEXT) && (state_d == S_IDLE);
        tmo_d   = set_tmo ? 1'b1 : (err_clr ? 1'b0 : tmo_q);
        ovr_d   = (tick && (state_q != S_IDLE)) ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            period_q <= PERIOD_RELOAD;
            wd_q     <= '0;
            mask_q   <= '0;
            ch_q     <= '0;
            start_q  <= 1'b0;
            filt_q   <= 1'b0;
            cmp_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            wd_q     <= wd_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            start_q  <= start_d;
            filt_q   <= filt_d;
            cmp_q    <= cmp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
        end
    end

    assign start_conversion = start_q;
    assign adc_channel      = ch_q;
    assign filter_enable    = filt_q;
    assign compare_enable   = cmp_q;
    assign busy             = busy_q;
    assign scan_done        = done_q;
    assign timeout_err      = tmo_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: scoreboard of expected channel starts and scan_done cycles, plus flag checks.
// Latency: expectations are absolute cycle numbers derived from the period and handshake delays.
// Backpressure: a behavioural responder returns data_ready/filter_done/compare_done after programmable delays.
module tb_acq_sequencer;

    localparam int P   = 20;
    localparam int TMO = 8;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic           clk;
    logic           reset;
    logic           enable;
    logic           single_shot;
    logic [NCH-1:0] ch_mask;
    logic           err_clr;
    logic           data_ready;
    logic           filter_done;
    logic           compare_done;
    logic           start_conversion;
    logic [CHW-1:0] adc_channel;
    logic           filter_enable;
    logic           compare_enable;
    logic           busy;
    logic           scan_done;
    logic           timeout_err;
    logic           overrun;

    acq_sequencer #(
        .SAMPLE_PERIOD(P),
        .TIMEOUT      (TMO),
        .NCH          (NCH),
        .CHW          (CHW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .single_shot     (single_shot),
        .ch_mask         (ch_mask),
        .err_clr         (err_clr),
        .data_ready      (data_ready),
        .filter_done     (filter_done),
        .compare_done    (compare_done),
        .start_conversion(start_conversion),
        .adc_channel     (adc_channel),
        .filter_enable   (filter_enable),
        .compare_enable  (compare_enable),
        .busy            (busy),
        .scan_done       (scan_done),
        .timeout_err     (timeout_err),
        .overrun         (overrun)
    );

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t start_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   cur_ch   = 0;
    int   dr_delay = 1;
    int   fd_delay = 1;
    int   cd_delay = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic int out_pack();
        return int'({start_conversion, adc_channel, filter_enable, compare_enable,
                     busy, scan_done, timeout_err, overrun});
    endfunction

    task automatic push_start(input int ch, input int c);
        exp_t e;
        e.ch  = ch;
        e.cyc = c;
        start_q.push_back(e);
    endtask

    // Behavioural ADC / filter / comparator: each done follows its request after a programmable delay.
    initial begin
        bit wait_act;
        int wait_k;
        int fk;
        int ck;
        wait_act     = 1'b0;
        wait_k       = 0;
        fk           = 0;
        ck           = 0;
        data_ready   = 1'b0;
        filter_done  = 1'b0;
        compare_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) wait_act = 1'b0;
            if (start_conversion) begin
                wait_act = 1'b1;
                wait_k   = 0;
            end else if (wait_act) begin
                wait_k++;
            end
            if (filter_enable) wait_act = 1'b0;
            data_ready   = wait_act && (wait_k >= dr_delay);
            fk           = filter_enable ? fk + 1 : 0;
            filter_done  = filter_enable && (fk >= fd_delay);
            ck           = compare_enable ? ck + 1 : 0;
            compare_done = compare_enable && (ck >= cd_delay);
        end
    end

    // Scoreboard: every start pulse and scan_done must match the head of its expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (start_conversion) begin
            check_val("start_expected", int'(start_q.size() != 0), 1);
            if (start_q.size() != 0) begin
                e = start_q.pop_front();
                check_val("start_ch", int'(adc_channel), e.ch);
                check_val("start_cyc", cyc, e.cyc);
            end
            cur_ch = int'(adc_channel);
        end else if (busy) begin
            check_val("ch_stable", int'(adc_channel), cur_ch);
        end
        if (scan_done) begin
            check_val("done_expected", int'(done_q.size() != 0), 1);
            if (done_q.size() != 0) begin
                check_val("done_cyc", cyc, done_q.pop_front());
            end
        end
    end

    initial begin
        int r;
        int n;
        reset       = 1'b0;
        enable      = 1'b0;
        single_shot = 1'b0;
        ch_mask     = '0;
        err_clr     = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_val("reset_outputs", out_pack(), 0);

        // Periodic scan of channels 1 and 3; enable dropped mid third scan.
        r       = cyc;
        reset   = 1'b1;
        enable  = 1'b1;
        ch_mask = 4'b1010;
        for (int k = 1; k <= 3; k++) begin
            push_start(1, r + P * k);
            push_start(3, r + P * k + 5);
            done_q.push_back(r + P * k + 10);
        end
        to_cyc(r + 62);
        enable = 1'b0;
        to_cyc(r + 110);
        check_val("p1_starts_left", start_q.size(), 0);
        check_val("p1_done_left", done_q.size(), 0);
        check_val("p1_idle_outputs", out_pack() & 32'h1F, 0);

        // Empty mask: single_shot ignored.
        n           = cyc;
        ch_mask     = 4'b0000;
        single_shot = 1'b1;
        to_cyc(n + 1);
        single_shot = 1'b0;
        check_val("mask0_busy", busy, 0);
        to_cyc(n + 8);
        check_val("mask0_flags", {timeout_err, overrun}, 0);

        // Single shot on channel 2; mask change and single_shot while busy have no effect.
        n           = cyc;
        ch_mask     = 4'b0100;
        single_shot = 1'b1;
        push_start(2, n + 1);
        done_q.push_back(n + 6);
        to_cyc(n + 1);
        single_shot = 1'b0;
        ch_mask     = 4'b1111;
        to_cyc(n + 3);
        single_shot = 1'b1;
        to_cyc(n + 4);
        single_shot = 1'b0;
        to_cyc(n + 10);
        check_val("ss_busy_overrun", overrun, 0);
        check_val("ss_starts_left", start_q.size(), 0);
        check_val("ss_done_left", done_q.size(), 0);

        // Watchdog in WAIT_ADC: data_ready withheld, remaining channel skipped.
        dr_delay    = 100;
        n           = cyc;
        ch_mask     = 4'b0011;
        single_shot = 1'b1;
        push_start(0, n + 1);
        to_cyc(n + 1);
        single_shot = 1'b0;
        to_cyc(n + 9);
        check_val("tmo_pre_err", timeout_err, 0);
        check_val("tmo_pre_busy", busy, 1);
        to_cyc(n + 10);
        check_val("tmo_err", timeout_err, 1);
        check_val("tmo_busy", busy, 0);
        dr_delay = 1;
        to_cyc(n + 14);
        check_val("tmo_sticky", timeout_err, 1);
        err_clr = 1'b1;
        to_cyc(n + 15);
        err_clr = 1'b0;
        check_val("tmo_cleared", timeout_err, 0);
        check_val("tmo_starts_left", start_q.size(), 0);

        // compare_done on the expiry cycle wins.
        cd_delay    = TMO;
        n           = cyc;
        ch_mask     = 4'b0001;
        single_shot = 1'b1;
        push_start(0, n + 1);
        done_q.push_back(n + 13);
        to_cyc(n + 1);
        single_shot = 1'b0;
        to_cyc(n + 16);
        check_val("race_no_err", timeout_err, 0);
        check_val("race_done_left", done_q.size(), 0);

        // One cycle later it times out; set coincides with err_clr and wins.
        cd_delay    = TMO + 1;
        n           = cyc;
        single_shot = 1'b1;
        push_start(0, n + 1);
        to_cyc(n + 1);
        single_shot = 1'b0;
        to_cyc(n + 11);
        err_clr = 1'b1;
        to_cyc(n + 12);
        err_clr = 1'b0;
        check_val("setwins_err", timeout_err, 1);
        check_val("setwins_busy", busy, 0);
        to_cyc(n + 14);
        err_clr = 1'b1;
        to_cyc(n + 15);
        err_clr  = 1'b0;
        cd_delay = 1;
        check_val("setwins_cleared", timeout_err, 0);

        // Overrun: 4-channel scan outlasts the period; next scan starts on the following tick.
        n       = cyc;
        ch_mask = 4'b1111;
        enable  = 1'b1;
        for (int c = 0; c < 4; c++) push_start(c, n + P + 5 * c);
        done_q.push_back(n + P + 20);
        push_start(0, n + 3 * P);
        done_q.push_back(n + 3 * P + 5);
        to_cyc(n + 39);
        check_val("ovr_pre", overrun, 0);
        to_cyc(n + 40);
        check_val("ovr_set", overrun, 1);
        to_cyc(n + 45);
        ch_mask = 4'b0001;
        to_cyc(n + 62);
        enable = 1'b0;
        to_cyc(n + 70);
        check_val("ovr_sticky", overrun, 1);
        check_val("ovr_starts_left", start_q.size(), 0);
        check_val("ovr_done_left", done_q.size(), 0);
        err_clr = 1'b1;
        to_cyc(n + 71);
        err_clr = 1'b0;
        check_val("ovr_cleared", overrun, 0);

        // Reset mid-FILTER, then first tick one full period after release.
        fd_delay    = 100;
        n           = cyc;
        single_shot = 1'b1;
        push_start(0, n + 1);
        to_cyc(n + 1);
        single_shot = 1'b0;
        to_cyc(n + 5);
        check_val("rst_in_filter", filter_enable, 1);
        reset = 1'b0;
        #1;
        check_val("rst_async_outputs", out_pack(), 0);
        to_cyc(n + 6);
        check_val("rst_outputs", out_pack(), 0);
        fd_delay = 1;
        to_cyc(n + 8);
        r      = cyc;
        reset  = 1'b1;
        enable = 1'b1;
        push_start(0, r + P);
        done_q.push_back(r + P + 5);
        to_cyc(r + P - 1);
        check_val("rst_no_early_tick", busy, 0);
        to_cyc(r + P + 10);
        enable = 1'b0;
        check_val("rst_starts_left", start_q.size(), 0);
        check_val("rst_done_left", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Periodic acquisition scheduler for the ADC sample path: SPI ADC capture, then filter, then comparator.
- Generates the sample-rate tick and scans a masked set of ADC channels in ascending order.
- For each channel it issues start_conversion, waits for data_ready, runs the filter, then the comparator.
- Replaces the free-running control handshake; provides watchdog timeout and overrun reporting.

Parameters:
SAMPLE_PERIOD, 1000, clk cycles between scan ticks (>=2)
TIMEOUT, 256, max clk cycles allowed in any wait state before abort
NCH, 4, number of ADC channels (power of 2, >=2)
CHW, 2, channel index width, log2(NCH)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = periodic scanning enabled
single_shot  in  1  one-cycle pulse: start one scan now if idle
ch_mask  in  NCH  channels to scan; snapshot taken at scan start
err_clr  in  1  clears timeout_err and overrun
data_ready  in  1  SPI capture complete
filter_done  in  1  filter finished
compare_done  in  1  comparator finished
start_conversion  out  1  one-cycle pulse to SPI
adc_channel  out  CHW  channel being converted
filter_enable  out  1  level, high in FILTER state
compare_enable  out  1  level, high in COMPARE state
busy  out  1  state != IDLE
scan_done  out  1  one-cycle pulse after last channel completes
timeout_err  out  1  sticky watchdog error
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0): state IDLE, all outputs 0, adc_channel 0, period counter reloaded to SAMPLE_PERIOD-1, mask snapshot 0. Reset mid-scan aborts immediately; no scan_done.
- Period counter:
  - Counts down while enable=1; tick when it reaches 0, then reloads.
  - While enable=0 it is held at reload value.
- Scan trigger (IDLE only): tick or single_shot with ch_mask!=0 → latch mask, adc_channel = lowest set bit, go to START.
  - ch_mask==0: trigger ignored, no error.
- Tick while busy: set overrun, tick dropped.
- single_shot while busy: ignored, overrun not set.
- FSM states are IDLE, START, WAIT_ADC, FILTER, COMPARE, NEXT. All outputs are registered, Moore-decoded.
  - START: start_conversion=1 for exactly one cycle → WAIT_ADC.
  - WAIT_ADC: on data_ready=1 → FILTER.
  - FILTER: filter_enable=1; on filter_done=1 → COMPARE.
  - COMPARE: compare_enable=1; on compare_done=1 → NEXT.
  - NEXT (1 cycle): if a higher set bit exists in the snapshot → adc_channel = that index, go to START. Otherwise → IDLE, with scan_done=1 in the first IDLE cycle.
- adc_channel is stable from START through NEXT of each channel.
- Min latency per channel is 5 cycles (START, WAIT, FILTER, COMPARE, NEXT), with each done sampled at the earliest one cycle after state entry.
- Handshake inputs arriving in any other state are ignored.
- The filter runs on a divided clock, so filter_done can take many clk cycles; TIMEOUT must cover this.
- Watchdog:
  - Counter cleared on entry to WAIT_ADC, FILTER and COMPARE; increments each cycle in those states.
  - Reaching TIMEOUT-1 without the awaited input → set timeout_err, drop enables, go to IDLE with no scan_done. Remaining channels are skipped.
  - Awaited input and expiry in the same cycle: input wins, no error.
- enable deasserted mid-scan: current scan completes normally; no further ticks.
- err_clr: clears both sticky flags the next cycle. If set and clear coincide, set wins.
- Mask changes during a scan have no effect until the next scan start.

Test Plan:
- Reset mid-FILTER → all outputs 0 next cycle, busy=0, no scan_done; after release with enable=1, first tick occurs SAMPLE_PERIOD cycles later.
- SAMPLE_PERIOD=20, ch_mask=4'b1010, enable=1, data_ready/filter_done/compare_done each returned 1 cycle after request → start_conversion pulses with adc_channel=1 then 3; scan_done one cycle after channel 3 NEXT; repeats every 20 cycles.
- ch_mask=0, single_shot pulse → busy stays 0, no start_conversion, no flags.
- TIMEOUT=8, data_ready withheld → timeout_err=1 exactly 8 cycles after WAIT_ADC entry, busy=0, no scan_done; err_clr → timeout_err=0.
- SAMPLE_PERIOD=6, filter_done delayed 10 cycles → overrun=1, the in-progress scan still completes, and the next scan starts on the following tick.
- compare_done and watchdog expiry in the same cycle → NEXT entered, timeout_err stays 0.
